hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32I core.
- Sits beside the ID/EX boundary, directly upstream of the EX-stage forwarding logic.
- Inserts the single load-use bubble that forwarding cannot cover, freezes the whole pipeline while instruction or data memory is outstanding, and flushes wrong-path instructions on taken branches/jumps.
- Drives the load and flush enables of the PC and every stage register, and keeps stall/bubble performance counters.

Parameters:
- CNT_W, 32, width of the performance counters (stall_cycles, bubble_count, flush_count).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_rs1  in  5  rs1 of instruction in ID (rv32i_reg)
- id_rs2  in  5  rs2 of instruction in ID (rv32i_reg)
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination of instruction in EX (rv32i_reg)
- ex_opcode  in  7  opcode in EX (rv32i_opcode)
- br_taken  in  1  EX resolved a taken branch/jump this cycle
- imem_req  in  1  fetch request issued this cycle
- imem_resp  in  1  instruction memory response
- dmem_req  in  1  MEM stage issued a load/store this cycle
- dmem_resp  in  1  data memory response
- pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each  stage register load enables
- if_id_flush, id_ex_flush  out  1 each  load a NOP/all-zero control word instead of the upstream value
- load_use_stall  out  1  bubble being inserted this cycle
- stall_cycles, bubble_count, flush_count  out  CNT_W each  performance counters

Behaviour:
- Reset:
  - FSM enters RUN; imem_done and dmem_done are cleared; all counters are 0.
  - While rst is high, all *_load outputs are 0, all *_flush outputs are 1, and load_use_stall is 0.
- States: RUN, MEM_WAIT.
- RUN:
  - Entry condition for MEM_WAIT: (imem_req && !imem_resp) || (dmem_req && !dmem_resp).
  - In the entry cycle all *_load outputs are 0, and that cycle counts as a stall.
  - Otherwise the pipeline advances (all loads 1) unless the load-use or branch rules below apply.
- MEM_WAIT:
  - All *_load outputs are 0.
  - imem_done latches on imem_resp; dmem_done latches on dmem_resp.
  - An interface counts as complete when its done flag is set, its resp is asserted this cycle, or it was not requested on entry.
  - The requested-on-entry flags are captured at entry.
  - When both interfaces are complete: all loads are 1 in that same cycle, the FSM returns to RUN, and both done flags clear.
  - Responses may arrive in either order or in the same cycle.
- Load-use hazard, evaluated only when no memory stall applies that cycle:
  - Condition: ex_opcode == op_load && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)).
  - Response: pc_load=0, if_id_load=0, id_ex_load=1, id_ex_flush=1, ex_mem_load=1, mem_wb_load=1, load_use_stall=1.
  - Exactly one bubble: the next cycle EX holds the bubble, so detection deasserts naturally.
- Branch flush, applied when no memory stall applies:
  - On br_taken: pc_load=1, if_id_flush=1, id_ex_flush=1, and all loads are 1.
  - Branch flush overrides load-use, because the ID instruction is wrong-path.
  - If br_taken coincides with a memory stall, the frozen EX holds br_taken and the flush takes effect in the release cycle.
- Priority: rst > memory stall > branch flush > load-use > normal advance.
- Counters:
  - stall_cycles increments on every cycle in which pc_load == 0.
  - bubble_count increments on every load_use_stall.
  - flush_count increments on every applied branch flush.
  - All counters wrap modulo 2^CNT_W with no saturation.
- Reset mid-MEM_WAIT: return to RUN immediately; late responses arriving while in RUN with no matching request are ignored.
- Outputs are combinational from state plus inputs, with no added latency. The FSM and counters are registered.

Decomposition:
- hazard_state_t enum {RUN, MEM_WAIT} goes in rv32i_types, next to the existing op_load, rv32i_reg and rv32i_opcode.
- One natural sub-module: hazard_perf_cnt, holding the three CNT_W counters with increment strobes.

Test Plan:
- Load-use: EX lw x5 (ex_rd=5, op_load), ID add reading rs1=5 → exactly one cycle with load_use_stall=1, pc_load=0, id_ex_flush=1; the next cycle pc_load=1; bubble_count=1.
- x0 load: ex_rd=0 load with ID reading rs2=0 → no stall; all loads 1.
- Split memory responses: dmem_req held for 3 cycles then dmem_resp, with imem_resp arriving 1 cycle earlier → all loads 0 for 3 cycles, released on the dmem_resp cycle, stall_cycles=3.
- Branch during stall: br_taken=1 with an outstanding imem for 2 cycles → no flush while stalled; on release if_id_flush=id_ex_flush=1, pc_load=1, flush_count=1.
- Branch vs load-use in the same cycle → flush applied, load_use_stall=0, bubble_count unchanged.
- rst asserted mid-MEM_WAIT, then a stray imem_resp → FSM in RUN, counters 0, stray response ignored, pipeline advances.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I field types, opcodes and hazard controller state
package rv32i_types;
   typedef logic [4:0] rv32i_reg;
   typedef logic [6:0] rv32i_opcode;
   localparam rv32i_opcode op_load = 7'b0000011;
   typedef enum logic {RUN, MEM_WAIT} hazard_state_t;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: wrapping stall, bubble and flush performance counters
module hazard_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_inc,
   input  logic             bubble_inc,
   input  logic             flush_inc,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] bubble_count,
   output logic [CNT_W-1:0] flush_count
);
   always_ff @(posedge clk)
      if (rst) begin
         stall_cycles <= '0;
         bubble_count <= '0;
         flush_count  <= '0;
      end else begin
         stall_cycles <= stall_cycles + CNT_W'(stall_inc);
         bubble_count <= bubble_count + CNT_W'(bubble_inc);
         flush_count  <= flush_count + CNT_W'(flush_inc);
      end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubble, memory-wait freeze and branch flush control for the 5-stage core
module hazard_ctrl
   import rv32i_types::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  rv32i_reg         id_rs1,
   input  rv32i_reg         id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  rv32i_reg         ex_rd,
   input  rv32i_opcode      ex_opcode,
   input  logic             br_taken,
   input  logic             imem_req,
   input  logic             imem_resp,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   output logic             pc_load,
   output logic             if_id_load,
   output logic             id_ex_load,
   output logic             ex_mem_load,
   output logic             mem_wb_load,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             load_use_stall,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] bubble_count,
   output logic [CNT_W-1:0] flush_count
);
   hazard_state_t state;
   logic i_req, d_req, i_done, d_done;
   logic lu, enter, rel, mem_stall, go, flush_br;
   assign lu = ex_opcode == op_load && ex_rd != '0 &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
   assign enter = (imem_req && !imem_resp) || (dmem_req && !dmem_resp);
   assign rel = (i_done || imem_resp || !i_req) && (d_done || dmem_resp || !d_req);
   assign mem_stall = state == RUN ? enter : !rel;
   assign go = !rst && !mem_stall;
   assign flush_br = go && br_taken;
   assign load_use_stall = go && !br_taken && lu;
   assign pc_load = go && !load_use_stall;
   assign if_id_load = pc_load;
   assign id_ex_load = go;
   assign ex_mem_load = go;
   assign mem_wb_load = go;
   assign if_id_flush = rst || flush_br;
   assign id_ex_flush = rst || flush_br || load_use_stall;
   // a response in the entry cycle already completes that interface
   always_ff @(posedge clk)
      if (rst) begin
         state  <= RUN;
         i_req  <= 1'b0;
         d_req  <= 1'b0;
         i_done <= 1'b0;
         d_done <= 1'b0;
      end else if (state == RUN) begin
         if (enter) begin
            state  <= MEM_WAIT;
            i_req  <= imem_req;
            d_req  <= dmem_req;
            i_done <= imem_resp;
            d_done <= dmem_resp;
         end
      end else if (rel) begin
         state  <= RUN;
         i_done <= 1'b0;
         d_done <= 1'b0;
      end else begin
         i_done <= i_done || imem_resp;
         d_done <= d_done || dmem_resp;
      end
   hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .rst(rst),
      .stall_inc(!pc_load),
      .bubble_inc(load_use_stall),
      .flush_inc(flush_br),
      .stall_cycles(stall_cycles),
      .bubble_count(bubble_count),
      .flush_count(flush_count)
   );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl control outputs and counters
module tb_hazard_ctrl;
   import rv32i_types::*;
   localparam logic [7:0] ADV = 8'b11111_00_0;
   localparam logic [7:0] STL = 8'b00000_00_0;
   localparam logic [7:0] LU  = 8'b00111_01_1;
   localparam logic [7:0] BR  = 8'b11111_11_0;
   localparam logic [7:0] RST = 8'b00000_11_0;
   logic clk = 1'b1, rst;
   rv32i_reg id_rs1, id_rs2, ex_rd;
   rv32i_opcode ex_opcode;
   logic id_uses_rs1, id_uses_rs2, br_taken, imem_req, imem_resp, dmem_req, dmem_resp;
   logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load, if_id_flush, id_ex_flush, load_use_stall;
   logic [31:0] stall_cycles, bubble_count, flush_count;
   logic [31:0] m_stall = 0, m_bub = 0, m_fl = 0;
   logic [7:0] q[$];
   int total = 0, bad = 0;

   hazard_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_opcode(ex_opcode), .br_taken(br_taken), .imem_req(imem_req),
      .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
      .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
      .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .load_use_stall(load_use_stall), .stall_cycles(stall_cycles),
      .bubble_count(bubble_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (q.size() > 0) begin
         logic [7:0] exp, got;
         exp = q.pop_front();
         got = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                if_id_flush, id_ex_flush, load_use_stall};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL ctrl @%0t: got=%b expected=%b", $time, got, exp);
         end
      end

   task automatic clr();
      rst = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_opcode = 0;
      id_uses_rs1 = 0; id_uses_rs2 = 0; br_taken = 0;
      imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
   endtask

   task automatic cyc(input logic [7:0] exp);
      q.push_back(exp);
      if (exp == RST) begin
         m_stall = 0; m_bub = 0; m_fl = 0;
      end else begin
         m_stall += {31'd0, !exp[7]};
         m_bub   += {31'd0, exp[0]};
         m_fl    += {31'd0, exp == BR};
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr(); rst = 1; br_taken = 1; imem_req = 1; dmem_req = 1;
      cyc(RST); cyc(RST);
      total++;
      if ({stall_cycles, bubble_count, flush_count} !== 96'd0) begin
         bad++;
         $display("FAIL reset_cnt: got=%0d/%0d/%0d expected=0/0/0", stall_cycles, bubble_count, flush_count);
      end
      clr(); cyc(ADV);
   endtask

   task automatic test_load_use();
      clr(); ex_opcode = op_load; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; id_rs2 = 7; id_uses_rs2 = 1;
      cyc(LU);
      clr(); id_rs1 = 5; id_uses_rs1 = 1;
      cyc(ADV);
      total++;
      if (bubble_count !== 1 || stall_cycles !== 1) begin
         bad++;
         $display("FAIL load_use_cnt: got bub=%0d stall=%0d expected bub=1 stall=1", bubble_count, stall_cycles);
      end
      clr(); ex_opcode = op_load; ex_rd = 9; id_rs2 = 9; id_uses_rs2 = 0; id_rs1 = 9; id_uses_rs1 = 0;
      cyc(ADV);
      id_uses_rs2 = 1; cyc(LU);
      ex_opcode = 7'b0110011; cyc(ADV);
   endtask

   task automatic test_x0_load();
      clr(); ex_opcode = op_load; ex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1; id_uses_rs1 = 1;
      cyc(ADV);
      total++;
      if (bubble_count !== m_bub) begin
         bad++;
         $display("FAIL x0_load_bub: got=%0d expected=%0d", bubble_count, m_bub);
      end
   endtask

   task automatic test_split_mem();
      logic [31:0] s0;
      s0 = stall_cycles;
      clr(); imem_req = 1; dmem_req = 1; cyc(STL);
      imem_req = 0; cyc(STL);
      imem_resp = 1; cyc(STL);
      imem_resp = 0; dmem_resp = 1; cyc(ADV);
      clr(); cyc(ADV);
      total++;
      if (stall_cycles - s0 !== 3 || stall_cycles !== m_stall) begin
         bad++;
         $display("FAIL split_mem_stall: got=%0d expected=%0d", stall_cycles, m_stall);
      end
   endtask

   task automatic test_br_stall();
      logic [31:0] f0;
      f0 = flush_count;
      clr(); imem_req = 1; br_taken = 1; cyc(STL);
      imem_req = 0; cyc(STL);
      imem_resp = 1; cyc(BR);
      clr(); cyc(ADV);
      total++;
      if (flush_count - f0 !== 1 || flush_count !== m_fl) begin
         bad++;
         $display("FAIL br_stall_flush: got=%0d expected=%0d", flush_count, m_fl);
      end
   endtask

   task automatic test_br_vs_lu();
      logic [31:0] b0;
      b0 = bubble_count;
      clr(); ex_opcode = op_load; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1; br_taken = 1;
      cyc(BR);
      clr(); cyc(ADV);
      total++;
      if (bubble_count !== b0 || flush_count !== m_fl) begin
         bad++;
         $display("FAIL br_vs_lu: got bub=%0d fl=%0d expected bub=%0d fl=%0d", bubble_count, flush_count, b0, m_fl);
      end
   endtask

   task automatic test_back_to_back();
      clr(); imem_req = 1; dmem_req = 1; cyc(STL);
      clr(); imem_resp = 1; dmem_resp = 1; cyc(ADV);
      clr(); imem_req = 1; imem_resp = 1; dmem_req = 1; cyc(STL);
      clr(); dmem_resp = 1; cyc(ADV);
      clr(); dmem_req = 1; cyc(STL);
      clr(); cyc(STL);
      dmem_resp = 1; br_taken = 1; cyc(BR);
      clr(); cyc(ADV);
      total++;
      if (stall_cycles !== m_stall || flush_count !== m_fl) begin
         bad++;
         $display("FAIL back_to_back_cnt: got st=%0d fl=%0d expected st=%0d fl=%0d", stall_cycles, flush_count, m_stall, m_fl);
      end
   endtask

   task automatic test_rst_mid_wait();
      clr(); imem_req = 1; cyc(STL);
      imem_req = 0; cyc(STL);
      rst = 1; cyc(RST);
      clr(); imem_resp = 1; cyc(ADV);
      clr(); cyc(ADV);
      total++;
      if ({stall_cycles, bubble_count, flush_count} !== 96'd0) begin
         bad++;
         $display("FAIL rst_mid_wait_cnt: got=%0d/%0d/%0d expected=0/0/0", stall_cycles, bubble_count, flush_count);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_x0_load();
      test_split_mem();
      test_br_stall();
      test_br_vs_lu();
      test_back_to_back();
      test_rst_mid_wait();
      @(posedge clk); #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got=%0d expected=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
